// File: rtl/hazard_ctrl.sv
// Load-use stall, taken-branch flush and multi-cycle mul/div hold control for the 5-stage pipeline.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFID_src1,
  input  logic [4:0] IFID_src2,
  input  logic       IFID_uses_src2,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_dest,
  input  logic       branch_taken,
  input  logic       md_start,
  output logic       PC_write,
  output logic       IFID_write,
  output logic       IFID_flush,
  output logic       IDEX_bubble,
  output logic       EX_hold,
  output logic       EXMEM_bubble,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int CNT_W = $clog2(MD_LATENCY);
  // Start value covers the remaining hold cycles; it is zero when MD_LATENCY is 2.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MD_LATENCY - 2);

  typedef enum logic {
    RUN,
    MDBUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ldHaz;

  assign ldHaz = IDEX_MemRead && (IDEX_dest != 5'd0) &&
                 ((IDEX_dest == IFID_src1) ||
                  (IFID_uses_src2 && (IDEX_dest == IFID_src2)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_bubble  = 1'b0;
    EX_hold      = 1'b0;
    EXMEM_bubble = 1'b0;
    md_done      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          IFID_flush  = 1'b1;
          IDEX_bubble = 1'b1;
        end else if (md_start) begin
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          EX_hold      = 1'b1;
          EXMEM_bubble = 1'b1;
          cnt_d        = CNT_START;
          state_d      = MDBUSY;
        end else if (ldHaz) begin
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          IDEX_bubble = 1'b1;
        end
      end
      MDBUSY: begin
        if (cnt_q != '0) begin
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          EX_hold      = 1'b1;
          EXMEM_bubble = 1'b1;
          cnt_d        = cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign md_busy = (state_q == MDBUSY);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q;

  // Counts frozen-PC cycles, sticking at the top value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!PC_write && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-phase reference model of the pipeline controls.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] src1, src2, dest;
  logic       usesSrc2, memRead, branchTaken, mdStart;
  logic       pcWrite, ifidWrite, ifidFlush, idexBubble, exHold, exmemBubble, mdBusy, mdDone;
  logic [7:0] obsOut;
  logic [7:0] expOut;
  int         testsRun = 0;
  int         testsFailed = 0;
  int         mdPhase = 0;
  logic [31:0] modelStall = '0;
  logic [31:0] expStall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stallCount;
`endif

  hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .IFID_src1     (src1),
    .IFID_src2     (src2),
    .IFID_uses_src2(usesSrc2),
    .IDEX_MemRead  (memRead),
    .IDEX_dest     (dest),
    .branch_taken  (branchTaken),
    .md_start      (mdStart),
    .PC_write      (pcWrite),
    .IFID_write    (ifidWrite),
    .IFID_flush    (ifidFlush),
    .IDEX_bubble   (idexBubble),
    .EX_hold       (exHold),
    .EXMEM_bubble  (exmemBubble),
    .md_busy       (mdBusy),
    .md_done       (mdDone)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count   (stallCount)
`endif
  );

  always #5 clk = ~clk;

  assign obsOut = {pcWrite, ifidWrite, ifidFlush, idexBubble, exHold, exmemBubble, mdBusy, mdDone};

  // Reference model: mdPhase is the position of the current cycle within a mul/div op
  // (0 = no op in progress, 2..LAT = cycles after the start cycle).
  function automatic logic [7:0] modelOutputs(input logic br, md, mr, input logic [4:0] d, s1, s2,
                                              input logic us);
    logic hz;
    hz = mr && (d != 0) && ((d == s1) || (us && (d == s2)));
    if (mdPhase >= 2) return (mdPhase < LAT) ? 8'b0000_1110 : 8'b1100_0011;
    if (br) return 8'b1111_0000;
    if (md) return 8'b0000_1100;
    if (hz) return 8'b0001_0000;
    return 8'b1100_0000;
  endfunction

  // Drives one cycle of inputs at the falling edge, then predicts this cycle's
  // outputs and advances the model to the state after the coming rising edge.
  task automatic applyStimulus(input logic rst, br, md, mr, input logic [4:0] d, s1, s2,
                               input logic us);
    @(negedge clk);
    reset = rst; branchTaken = br; mdStart = md; memRead = mr;
    dest = d; src1 = s1; src2 = s2; usesSrc2 = us;
    #1;
    expOut   = modelOutputs(br, md, mr, d, s1, s2, us);
    expStall = modelStall;
    if (rst) modelStall = '0;
    else if (!expOut[7] && modelStall != 32'hFFFF_FFFF) modelStall = modelStall + 1;
    if (rst) mdPhase = 0;
    else if (mdPhase >= 2) mdPhase = (mdPhase == LAT) ? 0 : mdPhase + 1;
    else if (!br && md) mdPhase = 2;
    else mdPhase = 0;
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (obsOut !== 8'b1100_0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle: got %b want %b", obsOut, 8'b1100_0000);
    end
`ifdef HAZARD_STATS_EN
    testsRun++;
    if (stallCount !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_stats: got %0d want 0", stallCount);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [7:0] want [4] = '{8'b0001_0000, 8'b1100_0000, 8'b0001_0000, 8'b1100_0000};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: applyStimulus(0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 1'b0);
        1: applyStimulus(0, 0, 0, 0, 5'd8, 5'd8, 5'd3, 1'b0);
        2: applyStimulus(0, 0, 0, 1, 5'd9, 5'd4, 5'd9, 1'b1);
        default: applyStimulus(0, 0, 0, 0, 5'd9, 5'd4, 5'd9, 1'b1);
      endcase
      testsRun++;
      if (obsOut !== want[i] || obsOut !== expOut) begin
        testsFailed++;
        $display("[TB] FAIL load_use step%0d: got %b want %b", i, obsOut, want[i]);
      end
    end
  endtask

  task automatic test_no_stall();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1'b1);
        1: applyStimulus(0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 1'b0);
        default: applyStimulus(0, 0, 0, 0, 5'd7, 5'd7, 5'd7, 1'b1);
      endcase
      testsRun++;
      if (obsOut !== 8'b1100_0000) begin
        testsFailed++;
        $display("[TB] FAIL no_stall step%0d: got %b want %b", i, obsOut, 8'b1100_0000);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [7:0] want [5] = '{8'b0000_1100, 8'b0000_1110, 8'b0000_1110, 8'b1100_0011, 8'b1100_0000};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, (i < 4), 0, 5'd0, 5'd1, 5'd2, 1'b0);
      testsRun++;
      if (obsOut !== want[i] || obsOut !== expOut) begin
        testsFailed++;
        $display("[TB] FAIL muldiv cyc%0d: got %b want %b", i, obsOut, want[i]);
      end
    end
  endtask

  task automatic test_branch_priority();
    logic [7:0] want [3] = '{8'b1111_0000, 8'b1111_0000, 8'b1100_0000};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: applyStimulus(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1'b0);
        1: applyStimulus(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1'b0);
        default: applyStimulus(0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 1'b0);
      endcase
      testsRun++;
      if (obsOut !== want[i] || obsOut !== expOut) begin
        testsFailed++;
        $display("[TB] FAIL branch_prio step%0d: got %b want %b", i, obsOut, want[i]);
      end
    end
  endtask

  task automatic test_reset_mdbusy();
    logic sawDone = 1'b0;
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1'b0);
      sawDone |= mdDone;
      if (i == 0) begin
        testsRun++;
        if (obsOut !== 8'b1100_0000) begin
          testsFailed++;
          $display("[TB] FAIL reset_mdbusy_idle: got %b want %b", obsOut, 8'b1100_0000);
        end
      end
    end
    testsRun++;
    if (sawDone !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mdbusy_done: got %b want 0", sawDone);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, (i < 8), 0, 5'd0, 5'd0, 5'd0, 1'b0);
      testsRun++;
      if (obsOut !== expOut) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back cyc%0d: got %b want %b", i, obsOut, expOut);
      end
      if (i == 4 || i == 7) begin
        testsRun++;
        if (obsOut !== ((i == 4) ? 8'b0000_1100 : 8'b1100_0011)) begin
          testsFailed++;
          $display("[TB] FAIL back_to_back_edge cyc%0d: got %b", i, obsOut);
        end
      end
    end
  endtask

  task automatic test_stats();
`ifdef HAZARD_STATS_EN
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1'b0);
    testsRun++;
    if (stallCount !== 32'd4) begin
      testsFailed++;
      $display("[TB] FAIL stats_count: got %0d want 4", stallCount);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      testsRun++;
      if (obsOut !== expOut) begin
        testsFailed++;
        $display("[TB] FAIL random cyc%0d: got %b want %b", i, obsOut, expOut);
      end
`ifdef HAZARD_STATS_EN
      testsRun++;
      if (stallCount !== expStall) begin
        testsFailed++;
        $display("[TB] FAIL random_stats cyc%0d: got %0d want %0d", i, stallCount, expStall);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; branchTaken = 0; mdStart = 0; memRead = 0;
    dest = 0; src1 = 0; src2 = 0; usesSrc2 = 0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_muldiv();
    test_branch_priority();
    test_reset_mdbusy();
    test_back_to_back();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
